counter_table_arbiter: RTL and testbench

- Owns a table of 2^IDX_W two-bit branch counters. The table has a single access port.
- Arbitrates that port between fetch-side prediction lookups and execute-side resolution updates.
- Resolution updates are buffered in a small in-order queue. Lookups have priority, subject to an anti-starvation limit.
- Serves as the shared counter-table engine for the local, global and choice predictors of the tournament predictor.

---
 rtl/counter_table_arbiter_if.sv | 31 +++
 rtl/counter_table_arbiter.sv | 133 +++++++++++++
 tb/tb_counter_table_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_table_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_table_arbiter_if
// Purpose  : Lookup / prediction / update handshake bundle for the counter table.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_table_arbiter_if #(
    parameter int IDX_W = 4
);
    logic             lookupValid;
    logic [IDX_W-1:0] lookupIndex;
    logic             lookupReady;
    logic             predValid;
    logic             predTaken;
    logic             updValid;
    logic [IDX_W-1:0] updIndex;
    logic             updTaken;
    logic             updReady;
    logic             queueEmpty;

    modport master (
        output lookupValid, lookupIndex, updValid, updIndex, updTaken,
        input  lookupReady, predValid, predTaken, updReady, queueEmpty
    );

    modport slave (
        input  lookupValid, lookupIndex, updValid, updIndex, updTaken,
        output lookupReady, predValid, predTaken, updReady, queueEmpty
    );
endinterface
`default_nettype wire

// File: rtl/counter_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_table_arbiter
// Purpose  : Single-port 2-bit counter table shared by prediction lookups and
//            queued, in-order training updates with anti-starvation arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module counter_table_arbiter #(
    parameter int IDX_W        = 4,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clock,
    input  logic                  resetN,
    counter_table_arbiter_if.slave bus
);

    localparam int TBL_SIZE = 1 << IDX_W;
    localparam int PTR_W    = $clog2(QDEPTH);
    localparam int CNT_W    = $clog2(QDEPTH + 1);
    localparam int SC_W     = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] C_QFULL      = CNT_W'(QDEPTH);
    localparam logic [SC_W-1:0]  C_STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] C_PTR_LAST   = PTR_W'(QDEPTH - 1);

    logic [1:0]       r_table [TBL_SIZE];
    logic [IDX_W-1:0] r_q_idx [QDEPTH];
    logic             r_q_tkn [QDEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [SC_W-1:0]  r_starve;
    logic             r_pred_valid;
    logic             r_pred_taken;

    logic             w_nonempty;
    logic             w_full;
    logic             w_force;
    logic             w_grant_upd;
    logic             w_grant_lkp;
    logic             w_push;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_tkn;
    logic [1:0]       w_trained;

    // Saturating counter; strongly-taken drops straight to weakly-not-taken.
    function automatic logic [1:0] f_train(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b10 : 2'b00;
            2'b10:   nxt = taken ? 2'b11 : 2'b01;
            default: nxt = taken ? 2'b11 : 2'b01;
        endcase
        return nxt;
    endfunction

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == C_PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign w_nonempty      = (r_count != '0);
    assign w_full          = (r_count == C_QFULL);
    assign w_force         = w_nonempty && ((r_starve == C_STARVE_MAX) || w_full);
    assign w_grant_upd     = w_nonempty && (w_force || !bus.lookupValid);
    assign w_grant_lkp     = bus.lookupValid && !w_force;
    assign w_push          = bus.updValid && !w_full;

    assign w_head_idx      = r_q_idx[r_rd_ptr];
    assign w_head_tkn      = r_q_tkn[r_rd_ptr];
    assign w_trained       = f_train(r_table[w_head_idx], w_head_tkn);

    assign bus.lookupReady = !w_force;
    assign bus.updReady    = !w_full;
    assign bus.queueEmpty  = !w_nonempty;
    assign bus.predValid   = r_pred_valid;
    assign bus.predTaken   = r_pred_taken;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                r_table[i] <= 2'b00;
            end
        end else if (w_grant_upd) begin
            r_table[w_head_idx] <= w_trained;
        end
    end

    // Entry storage needs no reset: validity is carried entirely by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr] <= bus.updIndex;
            r_q_tkn[r_wr_ptr] <= bus.updTaken;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_grant_upd) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_grant_upd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_grant_upd || !w_nonempty) begin
                r_starve <= '0;
            end else if (w_grant_lkp && (r_starve != C_STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end

            r_pred_valid <= w_grant_lkp;
            if (w_grant_lkp) begin
                r_pred_taken <= r_table[bus.lookupIndex][1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_table_arbiter
// Purpose  : Randomized scoreboard bench for counter_table_arbiter against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_table_arbiter;

    localparam int IDX_W        = 4;
    localparam int QDEPTH       = 4;
    localparam int STARVE_LIMIT = 3;
    localparam int TBL_SIZE     = 1 << IDX_W;

    typedef struct {
        int due;
        int taken;
    } pred_t;

    typedef struct {
        int idx;
        int taken;
    } upd_t;

    logic clock;
    logic resetN;

    counter_table_arbiter_if #(.IDX_W(IDX_W)) bus ();

    counter_table_arbiter #(
        .IDX_W        (IDX_W),
        .QDEPTH       (QDEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    pred_t sb[$];
    upd_t  mq[$];
    int    tbl[TBL_SIZE];
    int    losses = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int model_train(input int c, input int taken);
        if (taken != 0) return (c < 3) ? c + 1 : 3;
        if (c == 3) return 1;
        return (c > 0) ? c - 1 : 0;
    endfunction

    // Reference model: evaluated mid-cycle, describes what the next posedge does.
    always @(negedge clock) begin : model
        int   cnt;
        bit   frc;
        bit   g_upd;
        bit   g_lkp;
        upd_t e;
        if (cyc > 0) begin
            cnt = mq.size();
            frc = (cnt != 0) && (losses >= STARVE_LIMIT || cnt == QDEPTH);
            check("lookupReady", int'(bus.lookupReady), int'(!frc));
            check("updReady",    int'(bus.updReady),    int'(cnt < QDEPTH));
            check("queueEmpty",  int'(bus.queueEmpty),  int'(cnt == 0));
            if (!resetN) begin
                mq.delete();
                losses = 0;
                foreach (tbl[i]) tbl[i] = 0;
            end else begin
                g_upd = (cnt != 0) && (frc || !bus.lookupValid);
                g_lkp = bus.lookupValid && !frc;
                if (g_lkp) sb.push_back('{due: cyc + 1, taken: int'(tbl[bus.lookupIndex] >= 2)});
                if (g_upd) begin
                    e = mq.pop_front();
                    tbl[e.idx] = model_train(tbl[e.idx], e.taken);
                end
                if (bus.updValid && cnt < QDEPTH)
                    mq.push_back('{idx: int'(bus.updIndex), taken: int'(bus.updTaken)});
                if (g_upd || cnt == 0) losses = 0;
                else if (g_lkp && losses < STARVE_LIMIT) losses++;
            end
        end
    end

    always @(posedge clock) begin : monitor
        pred_t p;
        #2;
        if (bus.predValid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_pred: got predValid=1 required predValid=0 (cycle %0d)", cyc);
            end else begin
                p = sb.pop_front();
                check("pred_cycle", cyc, p.due);
                check("predTaken", int'(bus.predTaken), p.taken);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            p = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pred: got predValid=0 required predValid=1 (cycle %0d)", cyc);
        end
    end

    task automatic drive(input bit lv, input int li, input bit uv, input int ui,
                         input bit ut, input bit rn);
        @(posedge clock);
        #1;
        bus.lookupValid = lv;
        bus.lookupIndex = IDX_W'(li);
        bus.updValid    = uv;
        bus.updIndex    = IDX_W'(ui);
        bus.updTaken    = ut;
        resetN          = rn;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic drain;
        for (int i = 0; i < 50 && bus.queueEmpty !== 1'b1; i++) idle(1);
        check("drain_done", int'(bus.queueEmpty === 1'b1), 1);
    endtask

    initial begin
        resetN          = 1'b0;
        bus.lookupValid = 1'b0;
        bus.lookupIndex = '0;
        bus.updValid    = 1'b0;
        bus.updIndex    = '0;
        bus.updTaken    = 1'b0;
        repeat (2) drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

        drive(1'b1, 5, 1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // Counter walk on index 3: T,T,T -> ST, then NT -> WNT.
        repeat (3) drive(1'b0, 0, 1'b1, 3, 1'b1, 1'b1);
        idle(2);
        drive(1'b1, 3, 1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b1, 3, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 3, 1'b0, 0, 1'b0, 1'b1);
        idle(1);

        // One update starved by continuous lookups.
        drive(1'b1, 1, 1'b1, 7, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // Both requests every cycle: queue fills and forces pops.
        for (int i = 0; i < 12; i++) drive(1'b1, i, 1'b1, i % 3, 1'b1, 1'b1);
        drain();

        // Reset with updates still queued.
        drive(1'b1, 0, 1'b1, 9,  1'b1, 1'b1);
        drive(1'b1, 0, 1'b1, 10, 1'b1, 1'b1);
        drive(1'b1, 0, 1'b1, 11, 1'b1, 1'b1);
        drive(1'b1, 0, 1'b0, 0,  1'b0, 1'b0);
        drive(1'b1, 9,  1'b0, 0, 1'b0, 1'b1);
        drive(1'b1, 10, 1'b0, 0, 1'b0, 1'b1);
        drive(1'b1, 11, 1'b0, 0, 1'b0, 1'b1);
        idle(1);

        // Simultaneous lookup and update on an empty queue.
        drive(1'b1, 2, 1'b1, 2, 1'b1, 1'b1);
        idle(2);
        drive(1'b1, 2, 1'b0, 0, 1'b0, 1'b1);
        idle(1);

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 60,
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, TBL_SIZE - 1)),
                  $urandom_range(0, 99) < 50,
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, TBL_SIZE - 1)),
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 299) != 0);
        end

        drain();
        for (int i = 0; i < TBL_SIZE; i++) drive(1'b1, i, 1'b0, 0, 1'b0, 1'b1);
        idle(3);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
